// File: rtl/encryption_128.sv
// Iterative AES-128 encryption core, one cipher round per clock.
// A new plaintext/key pair is loaded whenever round reads 0, so the core runs
// free with an 11-clock period; round keys are expanded on the fly.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   plain_text   plaintext block, sampled only on the load edge
//   key          cipher key, sampled only on the load edge
//   encrypt_text most recently completed ciphertext (registered, held)
//   round        round counter 0..10 (registered); 0 marks a fresh result
module encryption_128 #(
    parameter int unsigned N = 128,
    parameter int unsigned R = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         plain_text,
    input  logic [N-1:0]         key,
    output logic [N-1:0]         encrypt_text,
    output logic [$clog2(R)-1:0] round
);

    localparam int unsigned RW = $clog2(R);
    localparam logic [RW-1:0] LastRound = RW'(R);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] Sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = Sbox[s[127-8*i -: 8]];
        return o;
    endfunction

    // Byte (row r, column c) lives at index 4c+r; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [RW-1:0] r);
        unique case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, t;
        {w0, w1, w2, w3} = k;
        rot = {w3[23:0], w3[31:24]};
        t   = {Sbox[rot[31:24]], Sbox[rot[23:16]], Sbox[rot[15:8]], Sbox[rot[7:0]]};
        t   = t ^ {rc, 24'h0};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0]  state_q, state_d;
    logic [127:0]  rk_q, rk_d;
    logic [127:0]  text_q, text_d;
    logic [RW-1:0] round_q, round_d;
    logic [127:0]  sr_sb;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        text_d  = text_q;
        round_d = round_q;
        sr_sb   = shift_rows(sub_bytes(state_q));
        if (round_q == '0) begin
            state_d = plain_text ^ key;
            rk_d    = key;
            round_d = RW'(1);
        end else begin
            rk_d = key_expand(rk_q, rcon(round_q));
            if (round_q >= LastRound) begin
                // Final round skips MixColumns and publishes the result.
                state_d = sr_sb ^ rk_d;
                text_d  = state_d;
                round_d = '0;
            end else begin
                state_d = mix_columns(sr_sb) ^ rk_d;
                round_d = round_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            rk_q    <= '0;
            text_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            text_q  <= text_d;
            round_q <= round_d;
        end
    end

    assign encrypt_text = text_q;
    assign round        = round_q;

endmodule

// File: tb/tb_encryption_128.sv
module tb_encryption_128;

    logic         clk;
    logic         rst_n;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic [127:0] encrypt_text;
    logic [3:0]   round;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] CtZero = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] PtBook = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KeyBook = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] CtBook = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [127:0] PtF1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KeyF1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CtF1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PtF2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyF2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CtF2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    encryption_128 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .plain_text   (plain_text),
        .key          (key),
        .encrypt_text (encrypt_text),
        .round        (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with random inputs.
        rst_n      = 1'b0;
        plain_text = {$urandom, $urandom, $urandom, $urandom};
        key        = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk4("reset_round", round, 4'd0);
            chk128("reset_text", encrypt_text, 128'h0);
            plain_text = {$urandom, $urandom, $urandom, $urandom};
            key        = {$urandom, $urandom, $urandom, $urandom};
        end

        // Zero vector at the first load edge; round steps 1..10 then 0.
        plain_text = '0;
        key        = '0;
        rst_n      = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            chk4("round_step", round, 4'(k));
        end
        chk128("text_before_first", encrypt_text, 128'h0);
        tick(1);
        chk4("round_wrap", round, 4'd0);
        chk128("zero_vector", encrypt_text, CtZero);

        // Textbook vector; previous result held until the final-round edge.
        plain_text = PtBook;
        key        = KeyBook;
        tick(5);
        chk128("zero_held_mid", encrypt_text, CtZero);
        tick(5);
        chk4("round_ten", round, 4'd10);
        chk128("zero_held_r10", encrypt_text, CtZero);
        tick(1);
        chk128("textbook", encrypt_text, CtBook);

        // FIPS-197 vectors back to back, 11 cycles apart.
        plain_text = PtF1;
        key        = KeyF1;
        tick(10);
        chk128("book_held", encrypt_text, CtBook);
        tick(1);
        chk4("fips1_round", round, 4'd0);
        chk128("fips1", encrypt_text, CtF1);
        plain_text = PtF2;
        key        = KeyF2;
        tick(11);
        chk128("fips2", encrypt_text, CtF2);

        // Inputs changed mid-block do not disturb the block in flight.
        plain_text = PtF1;
        key        = KeyF1;
        tick(5);
        chk4("mid_round5", round, 4'd5);
        plain_text = PtF2;
        key        = KeyF2;
        tick(6);
        chk128("mid_inflight", encrypt_text, CtF1);
        tick(11);
        chk128("mid_next", encrypt_text, CtF2);

        // Reset at round 7 discards the partial block.
        tick(7);
        chk4("pre_reset_round", round, 4'd7);
        rst_n      = 1'b0;
        plain_text = PtBook;
        key        = KeyBook;
        tick(1);
        chk4("midreset_round", round, 4'd0);
        chk128("midreset_text", encrypt_text, 128'h0);
        rst_n = 1'b1;
        tick(10);
        chk128("post_reset_hold", encrypt_text, 128'h0);
        tick(1);
        chk4("post_reset_round", round, 4'd0);
        chk128("post_reset", encrypt_text, CtBook);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
